// File: rtl/uart_tx_feeder.sv
// Byte FIFO that feeds a UART serializer: queues bytes, strobes txen per byte,
// and watches the serializer's busy flag for a missing start.
module uart_tx_feeder #(
  parameter int DEPTH    = 16,
  parameter int BUSY_TMO = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic [7:0]             wr_data,
  input  logic                   flush,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow,
  output logic                   busy_tmo,
  output logic                   txen,
  output logic [7:0]             tx_byte,
  input  logic                   tx_ing
);

  localparam int AW = $clog2(DEPTH);
  localparam int TW = (BUSY_TMO > 1) ? $clog2(BUSY_TMO) : 1;
  localparam logic [TW-1:0] TMO_LAST  = TW'(BUSY_TMO - 1);
  localparam logic [AW:0]   DEPTH_CNT = (AW + 1)'(DEPTH);

  localparam logic [1:0] S_IDLE      = 2'd0;
  localparam logic [1:0] S_LAUNCH    = 2'd1;
  localparam logic [1:0] S_WAIT_BUSY = 2'd2;
  localparam logic [1:0] S_WAIT_DONE = 2'd3;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count_nxt;
  logic [1:0]    state;
  logic [TW-1:0] tmo_cnt;
  logic          pop;
  logic          push;
  logic          drop;

  // Flush wins over a pop in the same cycle, so no launch starts from a flushed FIFO.
  always_comb begin
    pop       = (state == S_IDLE) && !empty && !tx_ing && !flush;
    push      = wr_en && !flush && (!full || pop);
    drop      = wr_en && !flush && full && !pop;
    count_nxt = count;
    if (flush) begin
      count_nxt = '0;
    end else if (push && !pop) begin
      count_nxt = count + 1'b1;
    end else if (pop && !push) begin
      count_nxt = count - 1'b1;
    end
  end

  // NOTE: storage is deliberately left out of reset; count/pointers define validity,
  // and a reset-free array maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // NOTE: all state here uses non-blocking assignments so every register sees
  // pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      full     <= 1'b0;
      empty    <= 1'b1;
      overflow <= 1'b0;
      busy_tmo <= 1'b0;
      txen     <= 1'b0;
      tx_byte  <= 8'h00;
      tmo_cnt  <= '0;
      state    <= S_IDLE;
    end else begin
      count    <= count_nxt;
      full     <= (count_nxt == DEPTH_CNT);
      empty    <= (count_nxt == '0);
      overflow <= drop;
      busy_tmo <= 1'b0;
      txen     <= (state == S_LAUNCH);

      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
      end

      case (state)
        S_IDLE: begin
          if (pop) begin
            tx_byte <= mem[rd_ptr];
            state   <= S_LAUNCH;
          end
        end
        S_LAUNCH: begin
          tmo_cnt <= '0;
          state   <= S_WAIT_BUSY;
        end
        S_WAIT_BUSY: begin
          // A serializer that never goes busy loses this byte; there is no retry.
          if (tx_ing) begin
            state <= S_WAIT_DONE;
          end else if (tmo_cnt == TMO_LAST) begin
            busy_tmo <= 1'b1;
            state    <= S_IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        S_WAIT_DONE: begin
          if (!tx_ing) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Scoreboard bench for uart_tx_feeder: pushed bytes are queued as expectations,
// a monitor pops and compares them on every txen strobe.
module tb_uart_tx_feeder;

  localparam int DEPTH    = 16;
  localparam int BUSY_TMO = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       flush;
  logic       full;
  logic       empty;
  logic [4:0] count;
  logic       overflow;
  logic       busy_tmo;
  logic       txen;
  logic [7:0] tx_byte;
  logic       tx_ing;

  logic tx_force;
  logic ser_busy;
  bit   ser_en;
  int   ser_len;

  int cyc = 0;
  int checks = 0;
  int errors = 0;
  int txen_cnt = 0;
  int txen_cyc = 0;
  int tmo_seen = 0;
  int tmo_cyc = 0;
  int ovf_seen = 0;
  int full_seen = 0;
  int last_push_cyc = 0;
  logic prev_txen = 1'b0;
  logic [7:0] sb [$];

  uart_tx_feeder #(.DEPTH(DEPTH), .BUSY_TMO(BUSY_TMO)) dut (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .flush    (flush),
    .full     (full),
    .empty    (empty),
    .count    (count),
    .overflow (overflow),
    .busy_tmo (busy_tmo),
    .txen     (txen),
    .tx_byte  (tx_byte),
    .tx_ing   (tx_ing)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign tx_ing = tx_force | ser_busy;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Serializer model: goes busy just after seeing txen, for ser_len cycles.
  initial begin
    ser_busy = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (ser_en && txen) begin
        ser_busy = 1'b1;
        repeat (ser_len) @(posedge clk);
        #1;
        ser_busy = 1'b0;
      end
    end
  end

  // Monitor: every txen must carry the oldest outstanding byte.
  always @(negedge clk) begin
    if (txen) begin
      txen_cnt++;
      txen_cyc = cyc;
      check("txen_back_to_back", {31'd0, prev_txen}, 32'd0);
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL txen_unexpected: got byte %0h expected no launch (cycle %0d)", tx_byte, cyc);
      end else begin
        check("tx_byte_order", {24'd0, tx_byte}, {24'd0, sb.pop_front()});
      end
    end
    if (overflow) ovf_seen++;
    if (busy_tmo) begin
      tmo_seen++;
      tmo_cyc = cyc;
    end
    if (full) full_seen++;
    prev_txen = txen;
  end

  task automatic push(input logic [7:0] b, input bit expect_ok);
    wr_en   = 1'b1;
    wr_data = b;
    @(negedge clk);
    wr_en = 1'b0;
    last_push_cyc = cyc;
    if (expect_ok) sb.push_back(b);
  endtask

  task automatic wait_txen(input int target, input int budget);
    int n = 0;
    while (txen_cnt < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("txen_timeout", {31'd0, (n < budget)}, 32'd1);
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while (!(sb.size() == 0 && !tx_ing && empty) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("drain_timeout", {31'd0, (n < budget)}, 32'd1);
    repeat (2) @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_count"},    {27'd0, count}, 32'd0);
    check({tag, "_empty"},    {31'd0, empty}, 32'd1);
    check({tag, "_full"},     {31'd0, full}, 32'd0);
    check({tag, "_txen"},     {31'd0, txen}, 32'd0);
    check({tag, "_tx_byte"},  {24'd0, tx_byte}, 32'd0);
    check({tag, "_overflow"}, {31'd0, overflow}, 32'd0);
    check({tag, "_busy_tmo"}, {31'd0, busy_tmo}, 32'd0);
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int n0, n1, o0, f0, t0, nn, em;
    rst = 1'b1; wr_en = 1'b0; wr_data = 8'h00; flush = 1'b0;
    tx_force = 1'b0; ser_en = 1'b1; ser_len = 4;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    @(negedge clk);

    // Single byte with a long serializer busy period.
    ser_len = 40;
    n0 = txen_cnt;
    push(8'hA5, 1'b1);
    wait_txen(n0 + 1, 20);
    check("single_latency", txen_cyc, last_push_cyc + 2);
    em = 0;
    repeat (45) begin
      @(negedge clk);
      if (!empty) em++;
    end
    check("single_empty_held", em, 0);
    check("single_txen_count", txen_cnt - n0, 1);
    wait_drain(200);

    // Back-to-back burst, 4-cycle serializer.
    ser_len = 4;
    n0 = txen_cnt; o0 = ovf_seen; f0 = full_seen;
    for (int i = 1; i <= 16; i++) push(8'(i), 1'b1);
    wait_drain(600);
    check("burst_txen_count", txen_cnt - n0, 16);
    check("burst_overflow", ovf_seen - o0, 0);
    check("burst_full", full_seen - f0, 0);

    // Fill while serializer is held busy, then overflow, then push during a pop.
    tx_force = 1'b1;
    n0 = txen_cnt; o0 = ovf_seen;
    for (int i = 0; i < 16; i++) push(8'h40 + 8'(i), 1'b1);
    check("fill_full", {31'd0, full}, 32'd1);
    check("fill_count", {27'd0, count}, 32'd16);
    push(8'h99, 1'b0);
    check("ovf_pulse", {31'd0, overflow}, 32'd1);
    check("ovf_count", {27'd0, count}, 32'd16);
    check("ovf_full", {31'd0, full}, 32'd1);
    @(negedge clk);
    check("ovf_pulse_width", {31'd0, overflow}, 32'd0);
    ser_len = 3;
    tx_force = 1'b0;
    push(8'hEE, 1'b1);
    check("pushpop_count", {27'd0, count}, 32'd16);
    check("pushpop_overflow", {31'd0, overflow}, 32'd0);
    wait_drain(800);
    check("fill_txen_count", txen_cnt - n0, 17);
    check("fill_overflow_total", ovf_seen - o0, 1);

    // Serializer never responds: busy timeout.
    ser_en = 1'b0;
    n0 = txen_cnt; t0 = tmo_seen;
    push(8'h3C, 1'b1);
    wait_txen(n0 + 1, 20);
    check("tmo_launch_latency", txen_cyc, last_push_cyc + 2);
    nn = 0;
    while (tmo_seen == t0 && nn < 20) begin
      @(negedge clk);
      nn++;
    end
    check("tmo_seen", {31'd0, (tmo_seen > t0)}, 32'd1);
    check("tmo_delay", tmo_cyc - txen_cyc, BUSY_TMO);
    check("tmo_count", {27'd0, count}, 32'd0);
    repeat (4) @(negedge clk);
    check("tmo_single_pulse", tmo_seen - t0, 1);
    ser_en = 1'b1; ser_len = 2;
    n0 = txen_cnt;
    push(8'h5A, 1'b1);
    wait_txen(n0 + 1, 20);
    check("tmo_relaunch_latency", txen_cyc, last_push_cyc + 2);
    wait_drain(200);

    // Flush while the first of five bytes is in flight; same-cycle push ignored.
    ser_len = 10;
    n0 = txen_cnt; o0 = ovf_seen;
    for (int i = 0; i < 5; i++) push(8'hB1 + 8'(i), 1'b1);
    wait_txen(n0 + 1, 20);
    sb.delete();
    flush = 1'b1; wr_en = 1'b1; wr_data = 8'h77;
    @(negedge clk);
    flush = 1'b0; wr_en = 1'b0;
    check("flush_count", {27'd0, count}, 32'd0);
    check("flush_empty", {31'd0, empty}, 32'd1);
    check("flush_overflow", {31'd0, overflow}, 32'd0);
    repeat (30) @(negedge clk);
    check("flush_txen_count", txen_cnt - n0, 1);
    check("flush_tx_byte_kept", {24'd0, tx_byte}, 32'hB1);
    check("flush_overflow_total", ovf_seen - o0, 0);
    wait_drain(200);

    // Reset while a byte is in flight; next launch waits for the serializer.
    n0 = txen_cnt;
    for (int i = 0; i < 5; i++) push(8'hC1 + 8'(i), 1'b1);
    wait_txen(n0 + 1, 20);
    sb.delete();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_reset_outputs("midrst");
    check("midrst_tx_ing_still_high", {31'd0, tx_ing}, 32'd1);
    push(8'hD7, 1'b1);
    n1 = txen_cnt;
    nn = 0;
    while (tx_ing && nn < 40) begin
      @(negedge clk);
      nn++;
    end
    check("midrst_no_launch_while_busy", txen_cnt - n1, 0);
    wait_txen(n1 + 1, 20);
    wait_drain(200);

    // Randomized batches against the queue model.
    for (int r = 0; r < 6; r++) begin
      ser_len = $urandom_range(1, 6);
      nn = $urandom_range(1, 12);
      o0 = ovf_seen;
      for (int k = 0; k < nn; k++) begin
        push(8'($urandom_range(0, 255)), 1'b1);
        repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      wait_drain(1000);
      check("rand_count", {27'd0, count}, 32'd0);
      check("rand_overflow", ovf_seen - o0, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
